// File: rtl/aes_coproc_pkg.sv
// aes_coproc_pkg: shared AES32 decode constants, op/entry-state enums, queue entry and GF(2^8) multiply
package aes_coproc_pkg;
    localparam logic [6:0] AES_OPCODE = 7'b0110011;
    localparam logic [2:0] AES_FUNCT3 = 3'b000;
    localparam logic [4:0] F5_ESI     = 5'b10001;
    localparam logic [4:0] F5_ESMI    = 5'b10011;
    localparam logic [4:0] F5_DSI     = 5'b10101;
    localparam logic [4:0] F5_DSMI    = 5'b10111;

    // Encoding equals funct5[2:1], so decode is a plain cast of those bits.
    typedef enum logic [1:0] {AES_ESI, AES_ESMI, AES_DSI, AES_DSMI} aes_op_e;
    typedef enum logic [1:0] {EMPTY, PENDING, COMMITTED, KILLED} entry_state_e;

    typedef struct packed {
        entry_state_e state;
        aes_op_e      op;
        logic [1:0]   bs;
        logic [4:0]   rd;
        logic [31:0]  rs1;
        logic [31:0]  rs2;
    } entry_t;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction
endpackage

// File: rtl/aes32_alu.sv
// aes32_alu: combinational aes32es(m)i / aes32ds(m)i datapath
// op: operation, bs: byte select, rs1: accumulator word, rs2: source word, rd: result
module aes32_alu
    import aes_coproc_pkg::*;
(
    input  aes_op_e     op,
    input  logic [1:0]  bs,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic [31:0] rd
);
    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    // Multiplicative inverse as a^254 by square-and-multiply; 0 maps to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] s, r;
        s = a;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            s = gf_mul(s, s);
            r = gf_mul(r, s);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        logic [7:0] y;
        y = gf_inv(x);
        return y ^ rotl8(y, 1) ^ rotl8(y, 2) ^ rotl8(y, 3) ^ rotl8(y, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] x);
        return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
    endfunction

    logic [7:0]  b, so;
    logic [31:0] mix;
    logic [63:0] rot;

    always_comb begin
        b   = rs2[{bs, 3'b000} +: 8];
        so  = (op == AES_DSI || op == AES_DSMI) ? sbox_inv(b) : sbox_fwd(b);
        mix = op == AES_ESMI ? {gf_mul(so, 8'h03), so, so, gf_mul(so, 8'h02)} :
              op == AES_DSMI ? {gf_mul(so, 8'h0b), gf_mul(so, 8'h0d), gf_mul(so, 8'h09), gf_mul(so, 8'h0e)} :
                               {24'h0, so};
        rot = {mix, mix} << {bs, 3'b000};
        rd  = rs1 ^ rot[63:32];
    end
endmodule

// File: rtl/aes32_xif_queue.sv
// aes32_xif_queue: in-order AES32 coprocessor queue on an issue/commit/result interface
// clk_i/rst_i: clock, sync active-high reset; issue_*: offload request, ready/accept/writeback response;
// commit_*: commit or kill a pending entry by ID; result_*: in-order writeback; occupancy_o: live entries
module aes32_xif_queue
    import aes_coproc_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int X_ID_WIDTH = 4,
    parameter bit ENABLE_ENC = 1'b1,
    parameter bit ENABLE_DEC = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    issue_valid_i,
    output logic                    issue_ready_o,
    input  logic [31:0]             issue_instr_i,
    input  logic [X_ID_WIDTH-1:0]   issue_id_i,
    input  logic [31:0]             issue_rs1_i,
    input  logic [31:0]             issue_rs2_i,
    input  logic [1:0]              issue_rs_valid_i,
    output logic                    issue_accept_o,
    output logic                    issue_writeback_o,
    input  logic                    commit_valid_i,
    input  logic [X_ID_WIDTH-1:0]   commit_id_i,
    input  logic                    commit_kill_i,
    output logic                    result_valid_o,
    input  logic                    result_ready_i,
    output logic [X_ID_WIDTH-1:0]   result_id_o,
    output logic [4:0]              result_rd_o,
    output logic [31:0]             result_data_o,
    output logic                    result_we_o,
    output logic [$clog2(DEPTH):0]  occupancy_o
);
    localparam int AW = $clog2(DEPTH);

    entry_t                ent [DEPTH];
    logic [X_ID_WIDTH-1:0] ids [DEPTH];
    logic [AW:0]           wptr, rptr;
    logic                  res_valid, is_aes, is_dec, full, enq, deq;
    entry_state_e          cstate;
    entry_t                head;
    logic [31:0]           alu_rd;

    assign is_aes = issue_instr_i[6:0] == AES_OPCODE && issue_instr_i[14:12] == AES_FUNCT3 &&
                    issue_instr_i[29:25] inside {F5_ESI, F5_ESMI, F5_DSI, F5_DSMI};
    assign is_dec = issue_instr_i[27];
    assign full   = wptr[AW] != rptr[AW] && wptr[AW-1:0] == rptr[AW-1:0];
    assign head   = ent[rptr[AW-1:0]];
    assign cstate = commit_kill_i ? KILLED : COMMITTED;

    assign issue_accept_o    = !rst_i && is_aes && (is_dec ? ENABLE_DEC : ENABLE_ENC);
    assign issue_writeback_o = issue_accept_o;
    assign issue_ready_o     = !rst_i && issue_valid_i && &issue_rs_valid_i && (!issue_accept_o || !full);
    assign enq               = issue_ready_o && issue_accept_o;
    // Killed heads leave without a result; committed heads leave on the result handshake.
    assign deq               = res_valid ? result_ready_i : head.state == KILLED;
    assign occupancy_o       = wptr - rptr;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr      <= '0;
            rptr      <= '0;
            res_valid <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                ent[i] <= '0;
                ids[i] <= '0;
            end
        end else begin
            if (commit_valid_i)
                for (int i = 0; i < DEPTH; i++)
                    if (ent[i].state == PENDING && ids[i] == commit_id_i) ent[i].state <= cstate;
            if (deq) begin
                ent[rptr[AW-1:0]].state <= EMPTY;
                rptr                    <= rptr + (AW+1)'(1);
            end
            // The tail slot is EMPTY here, so a same-cycle commit of this ID is folded in directly.
            if (enq) begin
                ent[wptr[AW-1:0]] <= '{state: (commit_valid_i && commit_id_i == issue_id_i) ? cstate : PENDING,
                                       op:    aes_op_e'(issue_instr_i[27:26]),
                                       bs:    issue_instr_i[31:30],
                                       rd:    issue_instr_i[11:7],
                                       rs1:   issue_rs1_i,
                                       rs2:   issue_rs2_i};
                ids[wptr[AW-1:0]] <= issue_id_i;
                wptr              <= wptr + (AW+1)'(1);
            end
            res_valid <= res_valid ? !result_ready_i : head.state == COMMITTED;
        end
    end

    aes32_alu u_alu (
        .op  (head.op),
        .bs  (head.bs),
        .rs1 (head.rs1),
        .rs2 (head.rs2),
        .rd  (alu_rd)
    );

    assign result_valid_o = res_valid;
    assign result_we_o    = res_valid;
    assign result_id_o    = res_valid ? ids[rptr[AW-1:0]] : '0;
    assign result_rd_o    = res_valid ? head.rd : '0;
    assign result_data_o  = res_valid ? alu_rd : '0;
endmodule

// File: tb/tb_aes32_xif_queue.sv
// tb_aes32_xif_queue: directed and randomized checks of aes32_xif_queue against a queue-level model
module tb_aes32_xif_queue;
    localparam int DEPTH = 4;

    logic        clk_i = 1'b0, rst_i = 1'b1;
    logic        issue_valid_i = 1'b0;
    logic [31:0] issue_instr_i = '0, issue_rs1_i = '0, issue_rs2_i = '0;
    logic [3:0]  issue_id_i = '0, commit_id_i = '0;
    logic [1:0]  issue_rs_valid_i = '0;
    logic        commit_valid_i = 1'b0, commit_kill_i = 1'b0, result_ready_i = 1'b0;
    logic        issue_ready_o, issue_accept_o, issue_writeback_o, result_valid_o, result_we_o;
    logic [3:0]  result_id_o;
    logic [4:0]  result_rd_o;
    logic [31:0] result_data_o;
    logic [2:0]  occupancy_o;
    logic        d2_ready, d2_accept, d2_wb, d2_rv, d2_we;
    logic [3:0]  d2_id;
    logic [4:0]  d2_rd;
    logic [31:0] d2_data;
    logic [2:0]  d2_occ;

    aes32_xif_queue #(.DEPTH(DEPTH), .X_ID_WIDTH(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_instr_i(issue_instr_i), .issue_id_i(issue_id_i), .issue_rs1_i(issue_rs1_i),
        .issue_rs2_i(issue_rs2_i), .issue_rs_valid_i(issue_rs_valid_i), .issue_accept_o(issue_accept_o),
        .issue_writeback_o(issue_writeback_o), .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i),
        .commit_kill_i(commit_kill_i), .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
        .result_id_o(result_id_o), .result_rd_o(result_rd_o), .result_data_o(result_data_o),
        .result_we_o(result_we_o), .occupancy_o(occupancy_o));

    aes32_xif_queue #(.DEPTH(DEPTH), .X_ID_WIDTH(4), .ENABLE_DEC(1'b0)) dut_nodec (
        .clk_i(clk_i), .rst_i(rst_i), .issue_valid_i(issue_valid_i), .issue_ready_o(d2_ready),
        .issue_instr_i(issue_instr_i), .issue_id_i(issue_id_i), .issue_rs1_i(issue_rs1_i),
        .issue_rs2_i(issue_rs2_i), .issue_rs_valid_i(issue_rs_valid_i), .issue_accept_o(d2_accept),
        .issue_writeback_o(d2_wb), .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i),
        .commit_kill_i(commit_kill_i), .result_valid_o(d2_rv), .result_ready_i(result_ready_i),
        .result_id_o(d2_id), .result_rd_o(d2_rd), .result_data_o(d2_data),
        .result_we_o(d2_we), .occupancy_o(d2_occ));

    always #5 clk_i = ~clk_i;

    int total = 0, bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference AES tables built by walking the multiplicative group with generator 3.
    logic [7:0] sb [256];
    logic [7:0] isb [256];

    function automatic logic [7:0] rl(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r, aa, bb;
        r = 0; aa = a; bb = b;
        while (bb != 0) begin
            if (bb[0]) r ^= aa;
            aa = (aa << 1) ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return r;
    endfunction

    task automatic build_tables();
        logic [7:0] p, q;
        p = 1; q = 1;
        do begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q ^= q << 1; q ^= q << 2; q ^= q << 4;
            if (q[7]) q ^= 8'h09;
            sb[p] = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4) ^ 8'h63;
        end while (p != 1);
        sb[0] = 8'h63;
        for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
    endtask

    function automatic logic [31:0] model_res(input int op, input int bs, input logic [31:0] rs1, input logic [31:0] rs2);
        logic [7:0]  b, s;
        logic [31:0] m;
        b = 8'(rs2 >> (8 * bs));
        s = op >= 2 ? isb[b] : sb[b];
        case (op)
            1:       m = {gmul(s, 3), s, s, gmul(s, 2)};
            3:       m = {gmul(s, 11), gmul(s, 13), gmul(s, 9), gmul(s, 14)};
            default: m = {24'h0, s};
        endcase
        return rs1 ^ ((m << (8 * bs)) | (m >> (32 - 8 * bs)));
    endfunction

    // Model: a FIFO of live instructions; st 1=pending 2=committed 3=killed.
    typedef struct { logic [3:0] id; logic [4:0] rd; logic [31:0] data; int st; } ment_t;
    ment_t mq[$];
    bit    mrv = 0;

    function automatic bit is_aes(input logic [31:0] ins);
        return ins[6:0] == 7'b0110011 && ins[14:12] == 3'b000 &&
               ins[29:25] inside {5'b10001, 5'b10011, 5'b10101, 5'b10111};
    endfunction
    function automatic bit m_accept();
        return !rst_i && is_aes(issue_instr_i);
    endfunction
    function automatic bit m_ready();
        return !rst_i && issue_valid_i && issue_rs_valid_i == 2'b11 && (!m_accept() || mq.size() < DEPTH);
    endfunction
    function automatic bit id_used(input logic [3:0] id);
        foreach (mq[i]) if (mq[i].id == id) return 1;
        return 0;
    endfunction

    // Inputs are stable between posedge+1 and the next posedge: compare, then advance the model
    // by the transition the coming edge will make.
    always @(negedge clk_i) begin
        ment_t n;
        bit    enq, pop, fire;
        chk("issue_ready", issue_ready_o, m_ready());
        chk("issue_accept", issue_accept_o, m_accept());
        chk("issue_writeback", issue_writeback_o, m_accept());
        chk("occupancy", occupancy_o, mq.size());
        chk("result_valid", result_valid_o, mrv);
        if (mrv && mq.size() > 0) begin
            chk("result_id", result_id_o, mq[0].id);
            chk("result_rd", result_rd_o, mq[0].rd);
            chk("result_data", result_data_o, mq[0].data);
            chk("result_we", result_we_o, 1);
        end else begin
            chk("idle_result_bus", {result_id_o, result_rd_o, result_we_o}, 0);
            chk("idle_result_data", result_data_o, 0);
        end
        if (rst_i) begin
            mq.delete();
            mrv = 0;
        end else begin
            enq  = m_ready() && m_accept();
            pop  = mrv ? result_ready_i : (mq.size() > 0 && mq[0].st == 3);
            fire = !mrv && mq.size() > 0 && mq[0].st == 2;
            if (commit_valid_i)
                foreach (mq[i]) if (mq[i].st == 1 && mq[i].id == commit_id_i) mq[i].st = commit_kill_i ? 3 : 2;
            if (pop) begin
                void'(mq.pop_front());
                mrv = 0;
            end
            if (fire) mrv = 1;
            if (enq) begin
                n.id   = issue_id_i;
                n.rd   = issue_instr_i[11:7];
                n.data = model_res(int'(issue_instr_i[27:26]), int'(issue_instr_i[31:30]), issue_rs1_i, issue_rs2_i);
                n.st   = (commit_valid_i && commit_id_i == issue_id_i) ? (commit_kill_i ? 3 : 2) : 1;
                mq.push_back(n);
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_issue(input logic [1:0] op, input logic [1:0] bs, input logic [4:0] rd,
                             input logic [3:0] id, input logic [31:0] rs1, input logic [31:0] rs2);
        issue_valid_i    = 1'b1;
        issue_instr_i    = {bs, 2'b10, op, 1'b1, 10'b0, 3'b000, rd, 7'b0110011};
        issue_id_i       = id;
        issue_rs1_i      = rs1;
        issue_rs2_i      = rs2;
        issue_rs_valid_i = 2'b11;
    endtask

    task automatic commit(input logic [3:0] id, input logic kill);
        commit_valid_i = 1'b1;
        commit_id_i    = id;
        commit_kill_i  = kill;
    endtask

    task automatic idle();
        issue_valid_i  = 1'b0;
        commit_valid_i = 1'b0;
        commit_kill_i  = 1'b0;
        result_ready_i = 1'b0;
    endtask

    task automatic wait_rv(input string name);
        int n = 0;
        while (!result_valid_o && n < 20) begin
            step();
            n++;
        end
        chk(name, result_valid_o, 1);
    endtask

    task automatic consume();
        result_ready_i = 1'b1;
        step();
        result_ready_i = 1'b0;
    endtask

    initial begin
        build_tables();
        chk("model_esmi_pin", model_res(1, 0, 0, 0), 32'hA56363C6);

        // Reset with a valid AES request on the bus: no ready, no accept.
        set_issue(2'd0, 2'd0, 5'd1, 4'd1, 0, 0);
        step();
        chk("rst_ready", issue_ready_o, 0);
        chk("rst_accept", issue_accept_o, 0);
        step(); step();
        rst_i = 1'b0;
        idle();
        chk("post_rst_occ", occupancy_o, 0);
        chk("post_rst_rv", result_valid_o, 0);

        // esi of zeros, committed a cycle later.
        set_issue(2'd0, 2'd0, 5'd1, 4'd3, 0, 0);
        step();
        idle();
        commit(4'd3, 1'b0);
        step();
        idle();
        wait_rv("esi_rv");
        chk("esi_data", result_data_o, 32'h00000063);
        chk("esi_id", result_id_o, 3);
        consume();

        // esmi and dsi with commit in the same cycle as enqueue.
        set_issue(2'd1, 2'd0, 5'd2, 4'd4, 0, 0);
        commit(4'd4, 1'b0);
        step();
        idle();
        wait_rv("esmi_rv");
        chk("esmi_data", result_data_o, 32'hA56363C6);
        consume();
        set_issue(2'd2, 2'd0, 5'd3, 4'd6, 0, 0);
        commit(4'd6, 1'b0);
        step();
        idle();
        wait_rv("dsi_rv");
        chk("dsi_data", result_data_o, 32'h00000052);
        consume();

        // Same-cycle commit gives a result one cycle later; reset mid-drain discards everything.
        set_issue(2'd1, 2'd2, 5'd4, 4'd5, 32'h1234_5678, 32'h9abc_def0);
        commit(4'd5, 1'b0);
        step();
        idle();
        step();
        chk("same_cycle_commit_rv", result_valid_o, 1);
        chk("same_cycle_commit_id", result_id_o, 5);
        set_issue(2'd3, 2'd1, 5'd5, 4'd7, 32'hdead_beef, 32'h0bad_f00d);
        commit(4'd7, 1'b0);
        step();
        idle();
        rst_i = 1'b1;
        step();
        chk("mid_drain_rst_rv", result_valid_o, 0);
        chk("mid_drain_rst_occ", occupancy_o, 0);
        rst_i = 1'b0;

        // Decrypt disabled: dsi and a plain add complete the handshake without enqueuing.
        set_issue(2'd2, 2'd0, 5'd6, 4'd8, 32'h1, 32'h2);
        #1;
        chk("nodec_dsi_ready", d2_ready, 1);
        chk("nodec_dsi_accept", d2_accept, 0);
        chk("nodec_dsi_wb", d2_wb, 0);
        step();
        chk("nodec_dsi_occ", d2_occ, 0);
        idle();
        commit(4'd8, 1'b1);
        step();
        idle();
        issue_valid_i    = 1'b1;
        issue_instr_i    = 32'h00B50533;
        issue_id_i       = 4'd9;
        issue_rs_valid_i = 2'b11;
        #1;
        chk("nonaes_ready", issue_ready_o, 1);
        chk("nonaes_accept", issue_accept_o, 0);
        chk("nonaes_d2_ready", d2_ready, 1);
        step();
        idle();
        chk("nonaes_occ", occupancy_o, 0);

        // Fill to DEPTH, fifth is held off until one result is drained.
        for (int i = 0; i < 4; i++) begin
            set_issue(2'(i), 2'(i), 5'(10 + i), 4'(8 + i), $urandom(), $urandom());
            step();
        end
        set_issue(2'd0, 2'd3, 5'd20, 4'd12, $urandom(), $urandom());
        #1;
        chk("full_ready", issue_ready_o, 0);
        chk("full_occ", occupancy_o, 4);
        commit(4'd8, 1'b0);
        step();
        commit_valid_i = 1'b0;
        chk("full_hold_ready", issue_ready_o, 0);
        wait_rv("full_head_rv");
        chk("full_head_id", result_id_o, 8);
        consume();
        chk("full_resume_ready", issue_ready_o, 1);
        step();
        idle();
        chk("full_refill_occ", occupancy_o, 4);
        for (int i = 9; i <= 12; i++) begin
            commit(4'(i), 1'b1);
            step();
        end
        idle();
        for (int n = 0; n < 20 && occupancy_o != 0; n++) step();
        chk("kill_drain_occ", occupancy_o, 0);

        // Kill the middle of three; results for 1 then 3.
        for (int i = 1; i <= 3; i++) begin
            set_issue(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 5'(i), 4'(i), $urandom(), $urandom());
            step();
        end
        idle();
        commit(4'd1, 1'b0); step();
        commit(4'd2, 1'b1); step();
        commit(4'd3, 1'b0); step();
        idle();
        wait_rv("order_first_rv");
        chk("order_first_id", result_id_o, 1);
        consume();
        wait_rv("order_second_rv");
        chk("order_second_id", result_id_o, 3);
        consume();
        step();
        chk("order_done_occ", occupancy_o, 0);

        // Randomized traffic; the negedge process checks every cycle against the model.
        for (int c = 0; c < 3000; c++) begin
            logic [3:0] id;
            int         r;
            rst_i = $urandom_range(0, 499) == 0;
            do id = 4'($urandom_range(0, 15)); while (id_used(id));
            set_issue(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
                      id, $urandom(), $urandom());
            issue_valid_i = $urandom_range(0, 2) != 0;
            if ($urandom_range(0, 7) == 0) issue_instr_i = $urandom();
            if ($urandom_range(0, 5) == 0) issue_rs_valid_i = 2'($urandom_range(0, 3));
            r = $urandom_range(0, 3);
            commit_valid_i = 1'b0;
            commit_kill_i  = $urandom_range(0, 3) == 0;
            if (r < 2 && mq.size() > 0) begin
                commit_valid_i = 1'b1;
                commit_id_i    = mq[$urandom_range(0, mq.size() - 1)].id;
            end else if (r == 2) begin
                commit_valid_i = 1'b1;
                commit_id_i    = id;
            end
            result_ready_i = $urandom_range(0, 1) != 0;
            step();
        end
        rst_i = 1'b0;
        idle();
        step(); step(); step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/aes32_xif_queue.md
AES32_XIF_QUEUE -- requirements
Module: aes32_xif_queue

Interface
REQ-001 Parameter DEPTH, default 4, in-flight instruction entries; SHALL be a power of two, at least 2.
REQ-002 Parameter X_ID_WIDTH, default 4, width of the instruction ID.
REQ-003 Parameter ENABLE_ENC, default 1, accepts aes32esi/aes32esmi.
REQ-004 Parameter ENABLE_DEC, default 1, accepts aes32dsi/aes32dsmi.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clk_i  in  1  clock.
REQ-007 rst_i  in  1  synchronous active-high reset.
REQ-008 issue_valid_i  in  1 / issue_ready_o  out  1  issue handshake.
REQ-009 issue_instr_i  in  32 / issue_id_i  in  X_ID_WIDTH / issue_rs1_i, issue_rs2_i  in  32 / issue_rs_valid_i  in  2  issue request.
REQ-010 issue_accept_o  out  1 / issue_writeback_o  out  1  issue response.
REQ-011 commit_valid_i  in  1 / commit_id_i  in  X_ID_WIDTH / commit_kill_i  in  1  commit.
REQ-012 result_valid_o  out  1 / result_ready_i  in  1 / result_id_o  out  X_ID_WIDTH / result_rd_o  out  5 / result_data_o  out  32 / result_we_o  out  1  result.
REQ-013 occupancy_o  out  $clog2(DEPTH)+1  valid entry count.

Function
REQ-014 Decode: opcode 0110011, funct3 000, funct5 10001 esi, 10011 esmi, 10101 dsi, 10111 dsmi; bs = instr[31:30], rd = instr[11:7].
REQ-015 issue_accept_o = decoded AES32 op AND its mode enable parameter is 1; issue_writeback_o = issue_accept_o.
REQ-016 issue_ready_o = issue_valid_i AND both rs_valid bits AND (NOT issue_accept_o OR queue not full); no path from result_ready_i.
REQ-017 Handshake with issue_accept_o=0 SHALL complete with no enqueue.
REQ-018 Accepted handshake SHALL enqueue {op, bs, rd, id, rs1, rs2} at the tail, state PENDING.
REQ-019 Full (occupancy = DEPTH): accepted instruction holds issue_ready_o low until a dequeue frees an entry; enqueue resumes the cycle after.
REQ-020 Commit: commit_valid_i marks the single PENDING entry with matching ID: KILLED if commit_kill_i, else COMMITTED; no match is ignored.
REQ-021 Commit in the same cycle as enqueue of the same ID SHALL apply to the newly enqueued entry.
REQ-022 Head KILLED: dequeued silently in one cycle, no result.
REQ-023 Head COMMITTED: result_valid_o=1 from the next cycle; data computed from head fields; result_we_o=1; outputs stable until result_ready_i.
REQ-024 Result handshake dequeues the head; next committed entry presents result_valid_o the following cycle (one result per two cycles max).
REQ-025 Results SHALL emerge in issue order; head PENDING blocks younger entries.
REQ-026 Pointers carry an extra wrap bit; full/empty from pointer compare; wrap-around SHALL be seamless.
REQ-027 Simultaneous enqueue and dequeue keep occupancy_o unchanged.
REQ-028 Result semantics per RISC-V Zkne/Zknd scalar aes32 ops: rd = rs1 XOR rotl(f(rs2 byte bs), 8*bs).
REQ-029 result outputs other than result_valid_o SHALL be 0 while result_valid_o=0.

Reset
REQ-030 rst_i SHALL clear all entries, both pointers, occupancy_o, result_valid_o and all result outputs to 0.
REQ-031 Reset mid-operation SHALL discard all in-flight entries with no result emitted.
REQ-032 issue_ready_o and issue_accept_o SHALL be 0 during reset.

Structure
REQ-033 Package aes_coproc_pkg SHALL hold opcode/funct3/funct5 constants, op enum aes_op_e, entry state enum (EMPTY, PENDING, COMMITTED, KILLED), entry struct.
REQ-034 Sub-module aes32_alu: combinational, inputs op, bs, rs1, rs2; output rd; holds forward/inverse S-box and (inverse) MixColumn.

Verification
REQ-035 esi, rs1=0, rs2=0, bs=0, id=3, commit id=3 -> result_data_o=0x00000063, result_id_o=3.
REQ-036 esmi, rs1=0, rs2=0, bs=0 -> 0xA56363C6; dsi same operands -> 0x00000052.
REQ-037 DEPTH=4: issue 5 accepted with no commits -> 5th sees issue_ready_o=0, occupancy_o=4; commit+drain head -> 5th enqueues next cycle.
REQ-038 IDs 1,2,3 issued; kill 2, commit 1,3 -> results for 1 then 3 only, in order.
REQ-039 ENABLE_DEC=0, dsi issued -> issue_ready_o=1, issue_accept_o=0, occupancy_o unchanged; non-AES opcode likewise.
REQ-040 Enqueue id=5 with commit id=5 same cycle -> result_valid_o=1 next cycle; rst_i asserted mid-drain -> result_valid_o=0, occupancy_o=0 next cycle.
